cpu_mailbox_bridge: RTL and testbench
=====================================

// Module: cpu_mailbox_bridge
// PURPOSE
//  Avalon-MM slave that terminates the CPU_1 exported outgoing master and implements a one-way
//  message mailbox from CPU_1 to CPU_2. CPU_1 pushes 32-bit words into a FIFO.
//  CPU_2 pops them through a second Avalon-MM slave port. Level interrupts signal data-available
//  to CPU_2 and space-available to CPU_1. Pipelined read timing matches the outgoing master.
// PARAMETERS
//  DEPTH          16           FIFO depth in words; power of two, 4..256
//  BASE_ADDR      28'h0000000  byte base of the 16-byte register window on port A
//  LOW_WM         4            CPU_1 space IRQ fires when count <= LOW_WM
// PORTS
//  clk_clk                      in   1   system clock, single domain
//  reset_reset_n                in   1   asynchronous active-low reset
//  cpu_1_outgoing_address       in   28  byte address from CPU_1
//  cpu_1_outgoing_writedata     in   32  write data
//  cpu_1_outgoing_byteenable    in   4   byte lanes
//  cpu_1_outgoing_write         in   1   write strobe
//  cpu_1_outgoing_read          in   1   read strobe
//  cpu_1_outgoing_burstcount    in   1   always 1; ignored
//  cpu_1_outgoing_debugaccess   in   1   ignored
//  cpu_1_outgoing_waitrequest   out  1   tied 0 (never stalls)
//  cpu_1_outgoing_readdata      out  32  read data, valid with readdatavalid
//  cpu_1_outgoing_readdatavalid out  1   one-cycle read response pulse
//  cpu_2_incoming_address       in   2   word offset from CPU_2
//  cpu_2_incoming_writedata     in   32  write data
//  cpu_2_incoming_write         in   1   write strobe
//  cpu_2_incoming_read          in   1   read strobe
//  cpu_2_incoming_readdata      out  32  read data, fixed read latency 1
//  irq_cpu_1                    out  1   space-available interrupt
//  irq_cpu_2                    out  1   data-available interrupt
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; IRQ enables 0; sticky flags 0; pointers 0. Async assert, sync release.
//  Port A decode: hit when address[27:4]==BASE_ADDR[27:4]; offset = address[3:2].
//   A+0 DATA wr: push word; disabled byte lanes written as 0x00. Read returns 0.
//   A+1 STATUS rd: [15:0]=count, [16]=full, [17]=empty, [31]=overflow sticky; wr bit31=1 clears it
//   A+2 IRQ_EN rw: bit0 enables irq_cpu_1. A+3 reserved: reads 0, writes dropped.
//   Miss: writes dropped; reads return 32'hDEADBEEF with normal valid timing.
//  Port A read: accepted on the cycle read=1 (waitrequest=0); readdatavalid=1 exactly the next cycle.
//   Back-to-back reads give back-to-back valid pulses. read and write in the same cycle: write wins; no response.
//  Port B offsets: B+0 DATA rd pops the head word; B+1 STATUS (same layout, [30]=underflow sticky;
//   wr bit30=1 clears it); B+2 IRQ_EN bit0 enables irq_cpu_2; B+3 reads 0.
//  Port B readdata is registered: data for the read in cycle N appears in N+1. Pop takes effect at N.
//  Push when full and no pop in the same cycle: word dropped, overflow=1.
//  Pop when empty: returns 0, no pointer change, underflow=1.
//  Push+pop same cycle: both succeed (including when full); count unchanged. Empty+push+pop: pop underflows, push lands.
//  Count width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
//  STATUS reads sample the count before that cycle's push/pop.
//  irq_cpu_2 = reg(en2 & !empty); irq_cpu_1 = reg(en1 & count<=LOW_WM); level, registered, 1-cycle lag.
// STRUCTURE
//  Package mbox_pkg: register offset localparams, STATUS bit positions, DECODE_MISS=32'hDEADBEEF.
//  Sub-module mbox_fifo: sync FIFO (push/pop/full/empty/count, DEPTH param).
//   Top level: decode, response pipeline, registers, IRQs.
// TESTING
//  Reset, then A reads STATUS -> readdatavalid 1 cycle later, data 0x0002_0000 (empty, count 0).
//  Push 0x11,0x22,0x33 via A+0; B pops three times -> 0x11,0x22,0x33 each 1 cycle after read; then empty.
//  Push DEPTH+1 words -> STATUS full=1, count=DEPTH, bit31=1; write 0x8000_0000 to STATUS -> bit31=0.
//  Full FIFO, push and pop same cycle -> count stays DEPTH, no overflow; popped word = oldest.
//  en2=1, push one word -> irq_cpu_2 rises within 2 cycles; pop -> falls; pop again -> 0 data, underflow=1.
//  A read at address 28'h0000100 (miss) -> 0xDEADBEEF; assert reset mid-stream -> FIFO empty, IRQs 0.

Source files
------------

// File: rtl/mbox_pkg.sv
// Shared definitions for the CPU_1 -> CPU_2 mailbox bridge.
// Register offsets, STATUS bit positions and the decode-miss pattern.
package mbox_pkg;

   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_IRQ_EN = 2'd2;
   localparam logic [1:0] OFF_RSVD   = 2'd3;

   localparam int ST_FULL  = 16;
   localparam int ST_EMPTY = 17;
   localparam int ST_UFLOW = 30;
   localparam int ST_OFLOW = 31;

   localparam logic [31:0] DECODE_MISS = 32'hDEAD_BEEF;

   function automatic logic [31:0] status_word(
      input logic [15:0] cnt,
      input logic        full,
      input logic        empty,
      input logic        uflow,
      input logic        oflow
   );
      logic [31:0] w;
      w           = {16'h0, cnt};
      w[ST_FULL]  = full;
      w[ST_EMPTY] = empty;
      w[ST_UFLOW] = uflow;
      w[ST_OFLOW] = oflow;
      return w;
   endfunction

endpackage

// File: rtl/mbox_fifo.sv
// Synchronous word FIFO for the mailbox; a pop frees a slot for a
// push in the same cycle, so a full FIFO accepts push+pop together.
module mbox_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata,
   output logic                     push_ok,
   output logic                     pop_ok,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cpu_mailbox_bridge.sv
// One-way CPU_1 -> CPU_2 mailbox: Avalon-MM slave A pushes words,
// slave B pops them; level IRQs report data/space availability.
module cpu_mailbox_bridge
   import mbox_pkg::*;
#(
   parameter int          DEPTH     = 16,
   parameter logic [27:0] BASE_ADDR = 28'h0000000,
   parameter int          LOW_WM    = 4
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic [27:0] cpu_1_outgoing_address,
   input  logic [31:0] cpu_1_outgoing_writedata,
   input  logic [3:0]  cpu_1_outgoing_byteenable,
   input  logic        cpu_1_outgoing_write,
   input  logic        cpu_1_outgoing_read,
   input  logic        cpu_1_outgoing_burstcount,
   input  logic        cpu_1_outgoing_debugaccess,
   output logic        cpu_1_outgoing_waitrequest,
   output logic [31:0] cpu_1_outgoing_readdata,
   output logic        cpu_1_outgoing_readdatavalid,
   input  logic [1:0]  cpu_2_incoming_address,
   input  logic [31:0] cpu_2_incoming_writedata,
   input  logic        cpu_2_incoming_write,
   input  logic        cpu_2_incoming_read,
   output logic [31:0] cpu_2_incoming_readdata,
   output logic        irq_cpu_1,
   output logic        irq_cpu_2
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [1:0]    rst_q;
   logic          rst_n;
   logic          a_hit;
   logic [1:0]    a_off;
   logic          a_wr;
   logic          a_rd;
   logic [31:0]   a_wdata;
   logic          push;
   logic          pop;
   logic          push_ok;
   logic          pop_ok;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic [31:0]   head;
   logic          oflow;
   logic          uflow;
   logic          en1;
   logic          en2;
   logic [31:0]   a_rdata_nxt;
   logic [31:0]   b_rdata_nxt;
   logic          unused;

   assign unused = ^{cpu_1_outgoing_burstcount,
                     cpu_1_outgoing_debugaccess,
                     cpu_1_outgoing_address[1:0]};

   // Async assert, release synchronised to clk_clk
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) rst_q <= 2'b00;
      else                rst_q <= {rst_q[0], 1'b1};
   end
   assign rst_n = rst_q[1];

   assign cpu_1_outgoing_waitrequest = 1'b0;

   assign a_hit = cpu_1_outgoing_address[27:4] == BASE_ADDR[27:4];
   assign a_off = cpu_1_outgoing_address[3:2];
   assign a_wr  = cpu_1_outgoing_write & a_hit;
   assign a_rd  = cpu_1_outgoing_read & ~cpu_1_outgoing_write;
   assign push  = a_wr & (a_off == OFF_DATA);
   assign pop   = cpu_2_incoming_read
                & (cpu_2_incoming_address == OFF_DATA);

   always_comb begin
      a_wdata = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (cpu_1_outgoing_byteenable[i])
            a_wdata[8*i +: 8] = cpu_1_outgoing_writedata[8*i +: 8];
      end
   end

   mbox_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk_clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .wdata   (a_wdata),
      .rdata   (head),
      .push_ok (push_ok),
      .pop_ok  (pop_ok),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   always_comb begin
      a_rdata_nxt = DECODE_MISS;
      if (a_hit) begin
         unique case (a_off)
            OFF_STATUS: a_rdata_nxt = status_word(16'(count), full,
                                                  empty, 1'b0, oflow);
            OFF_IRQ_EN: a_rdata_nxt = {31'h0, en1};
            default:    a_rdata_nxt = 32'h0;
         endcase
      end
   end

   always_comb begin
      b_rdata_nxt = 32'h0;
      unique case (cpu_2_incoming_address)
         OFF_DATA:   b_rdata_nxt = pop_ok ? head : 32'h0;
         OFF_STATUS: b_rdata_nxt = status_word(16'(count), full,
                                               empty, uflow, oflow);
         OFF_IRQ_EN: b_rdata_nxt = {31'h0, en2};
         OFF_RSVD:   b_rdata_nxt = 32'h0;
      endcase
   end

   // A fault raised this cycle outranks a simultaneous clear
   always_ff @(posedge clk_clk or negedge rst_n) begin
      if (!rst_n) begin
         oflow <= 1'b0;
         uflow <= 1'b0;
         en1   <= 1'b0;
         en2   <= 1'b0;
      end else begin
         if (push & ~push_ok)
            oflow <= 1'b1;
         else if (a_wr & (a_off == OFF_STATUS)
                  & cpu_1_outgoing_writedata[ST_OFLOW])
            oflow <= 1'b0;
         if (pop & ~pop_ok)
            uflow <= 1'b1;
         else if (cpu_2_incoming_write
                  & (cpu_2_incoming_address == OFF_STATUS)
                  & cpu_2_incoming_writedata[ST_UFLOW])
            uflow <= 1'b0;
         if (a_wr & (a_off == OFF_IRQ_EN))
            en1 <= cpu_1_outgoing_writedata[0];
         if (cpu_2_incoming_write
             & (cpu_2_incoming_address == OFF_IRQ_EN))
            en2 <= cpu_2_incoming_writedata[0];
      end
   end

   always_ff @(posedge clk_clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_1_outgoing_readdatavalid <= 1'b0;
         cpu_1_outgoing_readdata      <= 32'h0;
         cpu_2_incoming_readdata      <= 32'h0;
         irq_cpu_1                    <= 1'b0;
         irq_cpu_2                    <= 1'b0;
      end else begin
         cpu_1_outgoing_readdatavalid <= a_rd;
         cpu_1_outgoing_readdata      <= a_rd ? a_rdata_nxt : 32'h0;
         cpu_2_incoming_readdata      <= cpu_2_incoming_read
                                         ? b_rdata_nxt : 32'h0;
         irq_cpu_1 <= en1 & (count <= CW'(LOW_WM));
         irq_cpu_2 <= en2 & ~empty;
      end
   end

endmodule

// File: tb/tb_cpu_mailbox_bridge.sv
// Randomised bench for cpu_mailbox_bridge against a queue-based
// model of the mailbox registers, FIFO and interrupts.
module tb_cpu_mailbox_bridge;

   localparam int          DEPTH  = 16;
   localparam int          LOW_WM = 4;
   localparam logic [27:0] BASE   = 28'h0000000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [27:0] a_addr = '0;
   logic [31:0] a_wdata = '0;
   logic [3:0]  a_be = '0;
   logic        a_write = 1'b0;
   logic        a_read = 1'b0;
   logic        a_wait;
   logic [31:0] a_rdata;
   logic        a_rvalid;
   logic [1:0]  b_addr = '0;
   logic [31:0] b_wdata = '0;
   logic        b_write = 1'b0;
   logic        b_read = 1'b0;
   logic [31:0] b_rdata;
   logic        irq1;
   logic        irq2;

   int n_cmp = 0;
   int n_bad = 0;

   int unsigned q[$];
   bit en1, en2, of, uf;

   always #5 clk = ~clk;

   cpu_mailbox_bridge #(
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE),
      .LOW_WM    (LOW_WM)
   ) dut (
      .clk_clk                      (clk),
      .reset_reset_n                (rst_n),
      .cpu_1_outgoing_address       (a_addr),
      .cpu_1_outgoing_writedata     (a_wdata),
      .cpu_1_outgoing_byteenable    (a_be),
      .cpu_1_outgoing_write         (a_write),
      .cpu_1_outgoing_read          (a_read),
      .cpu_1_outgoing_burstcount    (1'b1),
      .cpu_1_outgoing_debugaccess   (1'b0),
      .cpu_1_outgoing_waitrequest   (a_wait),
      .cpu_1_outgoing_readdata      (a_rdata),
      .cpu_1_outgoing_readdatavalid (a_rvalid),
      .cpu_2_incoming_address       (b_addr),
      .cpu_2_incoming_writedata     (b_wdata),
      .cpu_2_incoming_write         (b_write),
      .cpu_2_incoming_read          (b_read),
      .cpu_2_incoming_readdata      (b_rdata),
      .irq_cpu_1                    (irq1),
      .irq_cpu_2                    (irq2)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h",
                  tag, $time, got, exp);
      end
   endtask

   function automatic logic [27:0] areg(input int off);
      return BASE + 28'(off * 4);
   endfunction

   function automatic logic [31:0] stat(input bit with_uf);
      logic [31:0] w;
      int c;
      c = q.size();
      w = 32'h0;
      w[15:0] = 16'(c);
      w[16] = (c == DEPTH);
      w[17] = (c == 0);
      w[30] = with_uf ? uf : 1'b0;
      w[31] = of;
      return w;
   endfunction

   function automatic void model_reset();
      q.delete();
      en1 = 0; en2 = 0; of = 0; uf = 0;
   endfunction

   // One clock: model predicts, DUT is driven, responses compared
   task automatic step(input bit aw, input bit ar,
                       input logic [27:0] aa, input logic [31:0] ad,
                       input logic [3:0] be, input bit bw,
                       input bit br, input logic [1:0] ba,
                       input logic [31:0] bd);
      bit hit, emp, ful, pop, pop_ok, set_of, set_uf, eav;
      logic [31:0] ea, eb, mw;
      logic [1:0] ao;
      bit ei1, ei2;
      int c;
      c   = q.size();
      emp = (c == 0);
      ful = (c == DEPTH);
      ei1 = en1 && (c <= LOW_WM);
      ei2 = en2 && !emp;
      hit = (aa[27:4] == BASE[27:4]);
      ao  = aa[3:2];
      eav = ar && !aw;
      ea  = 32'h0;
      if (eav) begin
         if (!hit)         ea = 32'hDEADBEEF;
         else if (ao == 1) ea = stat(0);
         else if (ao == 2) ea = {31'h0, en1};
      end
      pop    = br && (ba == 0);
      pop_ok = pop && !emp;
      set_uf = pop && emp;
      eb = 32'h0;
      if (br) begin
         if (ba == 0)      eb = pop_ok ? q[0] : 32'h0;
         else if (ba == 1) eb = stat(1);
         else if (ba == 2) eb = {31'h0, en2};
      end
      mw = 32'h0;
      for (int i = 0; i < 4; i++)
         if (be[i]) mw[8*i +: 8] = ad[8*i +: 8];
      set_of = 0;
      if (pop_ok) void'(q.pop_front());
      if (aw && hit && ao == 0) begin
         if (!ful || pop_ok) q.push_back(mw);
         else set_of = 1;
      end
      if (set_of) of = 1;
      else if (aw && hit && ao == 1 && ad[31]) of = 0;
      if (set_uf) uf = 1;
      else if (bw && ba == 1 && bd[30]) uf = 0;
      if (aw && hit && ao == 2) en1 = ad[0];
      if (bw && ba == 2) en2 = bd[0];

      a_write = aw; a_read = ar; a_addr = aa;
      a_wdata = ad; a_be = be;
      b_write = bw; b_read = br; b_addr = ba; b_wdata = bd;
      @(posedge clk);
      #1;
      chk("a_rvalid", {31'h0, a_rvalid}, {31'h0, eav});
      if (eav) chk("a_rdata", a_rdata, ea);
      chk("b_rdata", b_rdata, eb);
      chk("irq_cpu_1", {31'h0, irq1}, {31'h0, ei1});
      chk("irq_cpu_2", {31'h0, irq2}, {31'h0, ei2});
   endtask

   task automatic idle();
      step(0, 0, areg(0), 0, 4'h0, 0, 0, 2'd0, 0);
   endtask
   task automatic a_wr(input logic [27:0] a, input logic [31:0] d);
      step(1, 0, a, d, 4'hF, 0, 0, 2'd0, 0);
   endtask
   task automatic a_rd(input logic [27:0] a);
      step(0, 1, a, 0, 4'h0, 0, 0, 2'd0, 0);
   endtask
   task automatic b_rd(input logic [1:0] o);
      step(0, 0, areg(0), 0, 4'h0, 0, 1, o, 0);
   endtask
   task automatic b_wr(input logic [1:0] o, input logic [31:0] d);
      step(0, 0, areg(0), 0, 4'h0, 1, 0, o, d);
   endtask

   task automatic rand_step(input int push_pct, input int pop_pct);
      bit aw, ar, bw, br;
      logic [27:0] aa;
      logic [1:0] ba;
      int r;
      aw = ($urandom_range(99) < push_pct);
      ar = ($urandom_range(99) < 25);
      r  = $urandom_range(99);
      if (r < 6)       aa = 28'h0000100;
      else if (aw && r < 75) aa = areg(0);
      else             aa = areg($urandom_range(3));
      br = ($urandom_range(99) < pop_pct);
      bw = ($urandom_range(99) < 8);
      ba = ($urandom_range(99) < 70) ? 2'd0 : 2'($urandom_range(3));
      step(aw, ar, aa, $urandom, 4'($urandom), bw, br, ba, $urandom);
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rvalid", {31'h0, a_rvalid}, 32'h0);
      chk("rst_irq", {30'h0, irq1, irq2}, 32'h0);
      chk("rst_wait", {31'h0, a_wait}, 32'h0);
      rst_n = 1'b1;
      repeat (3) idle();

      a_rd(areg(1));
      chk("reset_status_const", stat(0), 32'h0002_0000);

      a_wr(areg(0), 32'h11);
      a_wr(areg(0), 32'h22);
      a_wr(areg(0), 32'h33);
      repeat (3) b_rd(2'd0);
      a_rd(areg(1));

      for (int i = 0; i <= DEPTH; i++) a_wr(areg(0), 32'hA000 + i);
      a_rd(areg(1));
      b_rd(2'd1);
      a_wr(areg(1), 32'h8000_0000);
      a_rd(areg(1));

      step(1, 0, areg(0), 32'hBEEF, 4'hF, 0, 1, 2'd0, 0);
      a_rd(areg(1));
      repeat (DEPTH) b_rd(2'd0);

      b_wr(2'd2, 32'h1);
      a_wr(areg(0), 32'h5555_AAAA);
      idle();
      idle();
      b_rd(2'd0);
      idle();
      b_rd(2'd0);
      b_rd(2'd1);
      b_wr(2'd1, 32'h4000_0000);
      b_rd(2'd1);
      b_rd(2'd2);

      a_wr(areg(2), 32'h1);
      idle();
      for (int i = 0; i < 6; i++) a_wr(areg(0), 32'h100 + i);
      idle();
      a_rd(areg(2));

      a_rd(28'h0000100);
      a_wr(28'h0000100, 32'h1234);
      a_rd(areg(3));
      a_wr(areg(3), 32'hFFFF);
      a_rd(areg(3));
      a_rd(areg(1));
      a_rd(areg(0));
      b_rd(2'd3);
      step(1, 1, areg(0), 32'h77, 4'hF, 0, 0, 2'd0, 0);
      step(0, 1, areg(1), 0, 4'h0, 0, 0, 2'd0, 0);
      step(0, 1, 28'h0000100, 0, 4'h0, 0, 0, 2'd0, 0);

      step(1, 0, areg(0), 32'hA1B2C3D4, 4'b0101, 0, 0, 2'd0, 0);
      while (q.size() > 0) b_rd(2'd0);
      step(1, 0, areg(0), 32'h99, 4'hF, 0, 1, 2'd0, 0);
      b_rd(2'd1);
      b_rd(2'd0);

      for (int i = 0; i < 600; i++) rand_step(70, 30);
      for (int i = 0; i < 600; i++) rand_step(35, 55);
      for (int i = 0; i < 400; i++) rand_step(50, 50);

      a_wr(areg(2), 32'h1);
      b_wr(2'd2, 32'h1);
      for (int i = 0; i < 5; i++) a_wr(areg(0), 32'hC0 + i);
      a_read = 1'b1;
      rst_n  = 1'b0;
      #1;
      chk("midrst_irq", {30'h0, irq1, irq2}, 32'h0);
      chk("midrst_rvalid", {31'h0, a_rvalid}, 32'h0);
      chk("midrst_brdata", b_rdata, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
      repeat (3) idle();
      a_rd(areg(1));
      b_rd(2'd0);
      a_rd(areg(2));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
